// File: rtl/adc_avg_decim_if.sv
// Result handshake bundle between the averaging decimator and the packer stage.
interface adc_avg_decim_if #(
    parameter int DW = 16
);
    logic [DW-1:0] avg_data;
    logic          avg_valid;
    logic          avg_ready;

    modport master (output avg_data, output avg_valid, input avg_ready);
    modport slave  (input avg_data, input avg_valid, output avg_ready);
endinterface

// File: rtl/adc_avg_decim.sv
// Boxcar average of 2^LOG2_N ADC samples, decimated to one word per window.
// Build option: define AVG_ROUND_EN for round-half-up with saturation instead of truncation.
module adc_avg_decim #(
    parameter int DW     = 16,
    parameter int LOG2_N = 3
) (
    input  logic                clk_100,
    input  logic                reset,
    input  logic                start,
    input  logic                cs_in,
    input  logic                en_in,
    input  logic [DW-1:0]       adc_data,
    adc_avg_decim_if.master     avg_if,
    output logic                overrun,
    output logic [LOG2_N-1:0]   win_cnt
);

`ifdef AVG_ROUND_EN
    localparam int ACC_W = DW + LOG2_N + 1;
    localparam logic [ACC_W-1:0] HALF = ACC_W'(1) << (LOG2_N - 1);
`else
    localparam int ACC_W = DW + LOG2_N;
`endif
    localparam logic [LOG2_N-1:0] WIN_LAST = '1;
    localparam logic [LOG2_N-1:0] WIN_ONE  = 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state_q, state_d;
    logic               cs_q;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [LOG2_N-1:0]  win_q, win_d;
    logic [DW-1:0]      data_q, data_d;
    logic               valid_q, valid_d;
    logic               ovr_q, ovr_d;

    logic               strobe;
    logic [ACC_W-1:0]   sum;
    logic [ACC_W-1:0]   shifted;
    logic [DW-1:0]      result;
    logic               fire;

    assign strobe = cs_in & ~cs_q & en_in & start;
    assign sum    = acc_q + {{(ACC_W-DW){1'b0}}, adc_data};

    always_ff @(posedge clk_100) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start)  state_d = RUN;
            RUN:     if (!start) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Window sum becomes the mean; with rounding the extra accumulator bit absorbs the half-LSB add.
    always_comb begin
        shifted = '0;
        result  = '0;
`ifdef AVG_ROUND_EN
        shifted = (sum + HALF) >> LOG2_N;
        result  = (|shifted[ACC_W-1:DW]) ? '1 : shifted[DW-1:0];
`else
        shifted = sum >> LOG2_N;
        result  = shifted[DW-1:0];
`endif
    end

    always_comb begin
        acc_d   = acc_q;
        win_d   = win_q;
        data_d  = data_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;
        fire    = 1'b0;
        if (state_q == RUN && start) begin
            if (strobe) begin
                if (win_q == WIN_LAST) begin
                    acc_d = '0;
                    win_d = '0;
                    fire  = 1'b1;
                end else begin
                    acc_d = sum;
                    win_d = win_q + WIN_ONE;
                end
            end
        end else begin
            acc_d = '0;
            win_d = '0;
        end
        // A new result may replace one that is being accepted in the same cycle.
        if (fire && (!valid_q || avg_if.avg_ready)) begin
            data_d  = result;
            valid_d = 1'b1;
        end else begin
            if (fire) begin
                ovr_d = 1'b1;
            end
            if (valid_q && avg_if.avg_ready) begin
                valid_d = 1'b0;
            end
        end
        if (!start) begin
            ovr_d = 1'b0;
        end
    end

    always_ff @(posedge clk_100) begin
        if (!reset) begin
            cs_q    <= 1'b0;
            acc_q   <= '0;
            win_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            cs_q    <= cs_in;
            acc_q   <= acc_d;
            win_q   <= win_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

    assign avg_if.avg_data  = data_q;
    assign avg_if.avg_valid = valid_q;
    assign overrun          = ovr_q;
    assign win_cnt          = win_q;

endmodule

// File: doc/adc_avg_decim.md
Name: adc_avg_decim

Overview:
- Downstream consumer of the ADC front-end (ADC or its imitator).
- Detects each new 16-bit sample and accumulates 2^LOG2_N samples, then emits their mean as one decimated word.
- Output uses a valid/ready handshake toward the packer/host-interface stage.
- Sits between the ADC sample source and the data-transfer logic in the 100 MHz domain.

Parameters:
- DW, 16, sample and output data width.
- LOG2_N, 3, log2 of window length; N = 2^LOG2_N samples per output (legal 1..8).

Ports:
- clk_100  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous reset, active-low (0 = reset).
- start  in  1  acquisition enable; same signal that drives the ADC stage.
- cs_in  in  1  CS from the ADC stage; its rising edge marks a new sample.
- en_in  in  1  en from the ADC stage; data valid qualifier (level).
- adc_data  in  DW  sample word from the ADC stage.
- avg_data  out  DW  decimated mean.
- avg_valid  out  1  avg_data holds an unaccepted result.
- avg_ready  in  1  downstream accepts avg_data.
- overrun  out  1  sticky: a completed window was dropped.
- win_cnt  out  LOG2_N  samples accumulated in the current window.

Behaviour:
- Reset: reset=0 at a clock edge clears all state. avg_data=0, avg_valid=0, overrun=0, win_cnt=0, accumulator=0, cs_d=0, FSM=IDLE. Reset overrides every other input, including mid-window and mid-handshake.
- Strobe: cs_d is cs_in registered. strobe = cs_in & ~cs_d & en_in & start. adc_data is sampled in the strobe cycle.
- Accumulator: DW+LOG2_N bits, unsigned, no saturation needed. The maximum sum N*(2^DW-1) fits.
- FSM states: IDLE and RUN.
- IDLE:
  - Accumulator and win_cnt held at 0.
  - Go to RUN when start=1. The strobe is not evaluated in the transition cycle because the FSM is not yet RUN.
  - The output register and overrun are left as they are.
- RUN:
  - On a strobe with win_cnt < N-1: acc <= acc + adc_data, win_cnt <= win_cnt + 1.
  - On a strobe with win_cnt = N-1: sum = acc + adc_data, result = sum >> LOG2_N (truncating). Then acc <= 0 and win_cnt <= 0, wrapping with no gap: the next strobe starts a new window.
  - A result is produced 1 cycle after the Nth strobe.
  - If avg_valid=0, or avg_valid=1 and avg_ready=1 in the same cycle: avg_data <= result, avg_valid <= 1.
  - Otherwise the result is discarded, avg_data is unchanged, and overrun <= 1.
  - start=0 in RUN: go to IDLE. The partial window is discarded (acc=0, win_cnt=0) and no result is produced. A pending avg_valid stays asserted until accepted.
- Handshake:
  - avg_valid deasserts on the cycle after avg_valid & avg_ready, unless a new result loads in that same cycle.
  - avg_data is stable while avg_valid=1 and avg_ready=0.
- overrun is cleared only by reset or by start=0. It is cleared in the first IDLE cycle.
- Boundary cases:
  - A strobe together with start falling: the sample is ignored.
  - A cs_in rising edge while en_in=0 is not a strobe and is ignored.
  - cs_in held high produces one strobe only.
  - LOG2_N-bit win_cnt wraps N-1 to 0 naturally.

Optional Feature:
- Macro: AVG_ROUND_EN.
- Defined: result = (sum + 2^(LOG2_N-1)) >> LOG2_N, round-half-up. The accumulator is widened by 1 bit so the rounding add cannot overflow. Result saturates at 2^DW-1.
- Not defined: truncating shift only, with no extra bit or adder.

Test Plan:
- Ramp: LOG2_N=3, start=1, avg_ready=1, strobes with data 1..8 then 9..16 -> avg_data=4 then 12. Each avg_valid is a 1-cycle pulse 1 cycle after the 8th strobe. With AVG_ROUND_EN: 5 then 13.
- Full scale: 8 strobes of 0xFFFF -> avg_data=0xFFFF, no wrap. With AVG_ROUND_EN: still 0xFFFF (saturated).
- Backpressure: avg_ready=0 across two windows (1..8, 9..16) -> avg_data stays 4, avg_valid=1, overrun=1. Then avg_ready=1 -> the value 4 is accepted and avg_valid drops. overrun stays 1 until start=0.
- Abort: 5 strobes of 0x0100, start=0 for 1 cycle, start=1, then 8 strobes of 0x1000 -> single result 0x1000, no result from the partial window, win_cnt=0 after the abort.
- Strobe qualification: cs_in rising with en_in=0, and cs_in held high 10 cycles -> no accumulation for the en_in=0 edge and exactly one strobe for the held-high edge. win_cnt is checked after each.
- Reset mid-window: 3 strobes, reset=0 for 1 cycle, then 8 strobes of 7 -> all outputs 0 during reset, next result 7.
